// File: rtl/uart_fifo_ctrl.sv
`default_nettype none
// =============================================================================
// Module : uart_fifo_ctrl
// Memory-mapped TX/RX FIFO front end with sticky error flags and irq for uart.
// Rev    : 1.0
// =============================================================================
module uart_fifo_ctrl #(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        sel_i,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [11:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o,
  output logic        uart_wr_o,
  output logic [7:0]  uart_tx_data_o,
  input  logic        uart_busy_i,
  output logic        uart_rd_o,
  input  logic [7:0]  uart_rx_data_i,
  input  logic        uart_valid_i
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [11:0]      c_addr_data   = 12'h000;
  localparam logic [11:0]      c_addr_status = 12'h004;
  localparam logic [11:0]      c_addr_ctrl   = 12'h008;
  localparam logic [LVL_W-1:0] c_lvl_full    = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] c_lvl_one     = LVL_W'(1);
  localparam logic [AW-1:0]    c_ptr_one     = AW'(1);

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_SEND    = 2'd1,
    TX_WAIT_HI = 2'd2,
    TX_WAIT_LO = 2'd3
  } tx_state_t;

  typedef enum logic [0:0] {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_t;

  tx_state_t        tx_state_q, tx_state_d;
  rx_state_t        rx_state_q, rx_state_d;
  logic [7:0]       tx_data_q, tx_data_d;

  logic [7:0]       tx_mem_q [DEPTH];
  logic [7:0]       rx_mem_q [DEPTH];
  logic [AW-1:0]    tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [AW-1:0]    rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [LVL_W-1:0] tx_level_q, tx_level_d, rx_level_q, rx_level_d;

  logic             rxovr_q, rxovr_d, txovf_q, txovf_d;
  logic             rxie_q, rxie_d, txie_q, txie_d;
  logic             irq_q, irq_d;

  logic w_data_wr, w_data_rd, w_stat_wr, w_ctrl_wr;
  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_rx_take;
  logic w_txbusy;
  logic w_unused;

  assign w_data_wr = sel_i && we_i && (addr_i == c_addr_data);
  assign w_data_rd = sel_i && re_i && (addr_i == c_addr_data);
  assign w_stat_wr = sel_i && we_i && (addr_i == c_addr_status);
  assign w_ctrl_wr = sel_i && we_i && (addr_i == c_addr_ctrl);

  // Full/empty come from the registered level, so a same-cycle pop never
  // makes room for a push into a full FIFO.
  assign w_tx_full  = (tx_level_q == c_lvl_full);
  assign w_tx_empty = (tx_level_q == '0);
  assign w_rx_full  = (rx_level_q == c_lvl_full);
  assign w_rx_empty = (rx_level_q == '0);

  assign w_tx_push = w_data_wr && !w_tx_full;
  assign w_tx_pop  = (tx_state_q == TX_IDLE) && !w_tx_empty;
  assign w_rx_take = (rx_state_q == RX_IDLE) && uart_valid_i;
  assign w_rx_push = w_rx_take && !w_rx_full;
  assign w_rx_pop  = w_data_rd && !w_rx_empty;

  assign w_txbusy = !w_tx_empty || (tx_state_q != TX_IDLE) || uart_busy_i;

  assign w_unused = ^{wdata_i[31:8], wdata_i[7:6], wdata_i[3:2]};

  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (!w_tx_empty) begin
          tx_data_d  = tx_mem_q[tx_rptr_q];
          tx_state_d = TX_SEND;
        end
      end
      TX_SEND:    tx_state_d = TX_WAIT_HI;
      TX_WAIT_HI: if (uart_busy_i)  tx_state_d = TX_WAIT_LO;
      TX_WAIT_LO: if (!uart_busy_i) tx_state_d = TX_IDLE;
      default:    tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE: if (uart_valid_i) rx_state_d = RX_ACK;
      RX_ACK:  rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    tx_wptr_d  = w_tx_push ? tx_wptr_q + c_ptr_one : tx_wptr_q;
    tx_rptr_d  = w_tx_pop  ? tx_rptr_q + c_ptr_one : tx_rptr_q;
    rx_wptr_d  = w_rx_push ? rx_wptr_q + c_ptr_one : rx_wptr_q;
    rx_rptr_d  = w_rx_pop  ? rx_rptr_q + c_ptr_one : rx_rptr_q;
    tx_level_d = tx_level_q;
    rx_level_d = rx_level_q;
    case ({w_tx_push, w_tx_pop})
      2'b10:   tx_level_d = tx_level_q + c_lvl_one;
      2'b01:   tx_level_d = tx_level_q - c_lvl_one;
      default: tx_level_d = tx_level_q;
    endcase
    case ({w_rx_push, w_rx_pop})
      2'b10:   rx_level_d = rx_level_q + c_lvl_one;
      2'b01:   rx_level_d = rx_level_q - c_lvl_one;
      default: rx_level_d = rx_level_q;
    endcase
  end

  // Clears are applied before sets so a same-cycle error event survives W1C.
  always_comb begin
    rxovr_d = rxovr_q;
    txovf_d = txovf_q;
    rxie_d  = rxie_q;
    txie_d  = txie_q;
    if (w_stat_wr && wdata_i[4]) rxovr_d = 1'b0;
    if (w_stat_wr && wdata_i[5]) txovf_d = 1'b0;
    if (w_rx_take && w_rx_full)  rxovr_d = 1'b1;
    if (w_data_wr && w_tx_full)  txovf_d = 1'b1;
    if (w_ctrl_wr) begin
      rxie_d = wdata_i[0];
      txie_d = wdata_i[1];
    end
    irq_d = (rxie_q && !w_rx_empty) || (txie_q && !w_txbusy);
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_IDLE;
      tx_data_q  <= '0;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      tx_level_q <= '0;
      rx_level_q <= '0;
      rxovr_q    <= 1'b0;
      txovf_q    <= 1'b0;
      rxie_q     <= 1'b0;
      txie_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      tx_data_q  <= tx_data_d;
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      tx_level_q <= tx_level_d;
      rx_level_q <= rx_level_d;
      rxovr_q    <= rxovr_d;
      txovf_q    <= txovf_d;
      rxie_q     <= rxie_d;
      txie_q     <= txie_d;
      irq_q      <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) tx_mem_q[tx_wptr_q] <= wdata_i[7:0];
    if (w_rx_push) rx_mem_q[rx_wptr_q] <= uart_rx_data_i;
  end

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      c_addr_data: begin
        if (!w_rx_empty) rdata_o = {24'd0, rx_mem_q[rx_rptr_q]};
      end
      c_addr_status: begin
        rdata_o = {8'd0, 8'(tx_level_q), 8'(rx_level_q), 2'b00,
                   txovf_q, rxovr_q, w_rx_full, w_tx_full, !w_rx_empty, w_txbusy};
      end
      c_addr_ctrl: rdata_o = {30'd0, txie_q, rxie_q};
      default:     rdata_o = '0;
    endcase
  end

  assign irq_o          = irq_q;
  assign uart_wr_o      = (tx_state_q == TX_SEND);
  assign uart_rd_o      = (rx_state_q == RX_ACK);
  assign uart_tx_data_o = tx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_ctrl.sv
`default_nettype none
// =============================================================================
// Module : tb_uart_fifo_ctrl
// Self-checking bench: queue-based reference model plus directed scenarios.
// Rev    : 1.0
// =============================================================================
module tb_uart_fifo_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        sel_i = 1'b0, we_i = 1'b0, re_i = 1'b0;
  logic [11:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        irq_o, uart_wr_o, uart_rd_o;
  logic [7:0]  uart_tx_data_o;
  logic        uart_busy_i = 1'b0;
  logic [7:0]  uart_rx_data_i = '0;
  logic        uart_valid_i = 1'b0;

  always #5 clk = ~clk;

  uart_fifo_ctrl #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_i        (reset_i),
    .sel_i          (sel_i),
    .we_i           (we_i),
    .re_i           (re_i),
    .addr_i         (addr_i),
    .wdata_i        (wdata_i),
    .rdata_o        (rdata_o),
    .irq_o          (irq_o),
    .uart_wr_o      (uart_wr_o),
    .uart_tx_data_o (uart_tx_data_o),
    .uart_busy_i    (uart_busy_i),
    .uart_rd_o      (uart_rd_o),
    .uart_rx_data_i (uart_rx_data_i),
    .uart_valid_i   (uart_valid_i)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc++;

  // Core stand-in: busy rises the cycle after a wr pulse and lasts busy_len
  // cycles; stall freezes it high.
  int busy_len = 10;
  bit stall    = 1'b0;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (reset_i)                    busy_cnt = 0;
    else if (uart_wr_o === 1'b1)    busy_cnt = busy_len;
    else if (busy_cnt > 0 && !stall) busy_cnt = busy_cnt - 1;
    #1 uart_busy_i = (busy_cnt > 0);
  end

  // Reference model: FIFOs as queues, transmitter as "pulse / awaiting busy /
  // awaiting drop" flags, all state as seen during the current cycle.
  logic [7:0] m_txq[$];
  logic [7:0] m_rxq[$];
  bit         m_rxovr, m_txovf, m_rxie, m_txie, m_irq;
  bit         m_wr, m_wait_hi, m_wait_lo, m_rd;
  logic [7:0] m_txdata = '0;

  function automatic bit m_txbusy();
    return (m_txq.size() != 0) || m_wr || m_wait_hi || m_wait_lo || (uart_busy_i === 1'b1);
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[0] = m_txbusy();
    s[1] = (m_rxq.size() != 0);
    s[2] = (m_txq.size() == DEPTH);
    s[3] = (m_rxq.size() == DEPTH);
    s[4] = m_rxovr;
    s[5] = m_txovf;
    s[15:8]  = 8'(m_rxq.size());
    s[23:16] = 8'(m_txq.size());
    return s;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [11:0] a);
    case (a)
      12'h000: return (m_rxq.size() != 0) ? {24'd0, m_rxq[0]} : 32'd0;
      12'h004: return m_status();
      12'h008: return {30'd0, m_txie, m_rxie};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin : p_model
    bit irq_n, tx_full0, rx_full0, rx_pop, rx_take;
    if (reset_i) begin
      m_txq.delete();
      m_rxq.delete();
      {m_rxovr, m_txovf, m_rxie, m_txie, m_irq} = '0;
      {m_wr, m_wait_hi, m_wait_lo, m_rd} = '0;
      m_txdata = '0;
    end else begin
      irq_n    = (m_rxie && m_rxq.size() != 0) || (m_txie && !m_txbusy());
      tx_full0 = (m_txq.size() == DEPTH);
      rx_full0 = (m_rxq.size() == DEPTH);
      rx_pop   = sel_i && re_i && addr_i == 12'h000 && m_rxq.size() != 0;
      rx_take  = !m_rd && uart_valid_i;
      if (m_wr) begin
        m_wr = 1'b0; m_wait_hi = 1'b1;
      end else if (m_wait_hi) begin
        if (uart_busy_i) begin m_wait_hi = 1'b0; m_wait_lo = 1'b1; end
      end else if (m_wait_lo) begin
        if (!uart_busy_i) m_wait_lo = 1'b0;
      end else if (m_txq.size() != 0) begin
        m_txdata = m_txq.pop_front();
        m_wr     = 1'b1;
      end
      if (sel_i && we_i && addr_i == 12'h004) begin
        if (wdata_i[4]) m_rxovr = 1'b0;
        if (wdata_i[5]) m_txovf = 1'b0;
      end
      if (sel_i && we_i && addr_i == 12'h008) begin
        m_rxie = wdata_i[0];
        m_txie = wdata_i[1];
      end
      if (sel_i && we_i && addr_i == 12'h000) begin
        if (!tx_full0) m_txq.push_back(wdata_i[7:0]);
        else           m_txovf = 1'b1;
      end
      if (rx_pop) void'(m_rxq.pop_front());
      m_rd = rx_take;
      if (rx_take) begin
        if (!rx_full0) m_rxq.push_back(uart_rx_data_i);
        else           m_rxovr = 1'b1;
      end
      m_irq = irq_n;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("rdata", rdata_o, exp_rdata(addr_i));
      check("irq", 32'(irq_o), 32'(m_irq));
      check("uart_wr", 32'(uart_wr_o), 32'(m_wr));
      check("uart_tx_data", 32'(uart_tx_data_o), 32'(m_txdata));
      check("uart_rd", 32'(uart_rd_o), 32'(m_rd));
    end
  end

  logic [7:0] wr_data[$];
  int         wr_cyc[$];
  int         rd_cnt = 0;
  always @(negedge clk) begin
    if (chk_on) begin
      if (uart_wr_o === 1'b1) begin
        wr_data.push_back(uart_tx_data_o);
        wr_cyc.push_back(cyc);
      end
      if (uart_rd_o === 1'b1) rd_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    sel_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
    step();
    sel_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
    sel_i = 1'b1; re_i = 1'b1; addr_i = a;
    @(negedge clk);
    d = rdata_o;
    step();
    sel_i = 1'b0; re_i = 1'b0;
  endtask

  task automatic peek(input logic [11:0] a, output logic [31:0] d, output int c);
    addr_i = a;
    @(negedge clk);
    d = rdata_o;
    c = cyc;
    step();
  endtask

  task automatic inject(input logic [7:0] b);
    uart_valid_i = 1'b1; uart_rx_data_i = b;
    step();
    uart_valid_i = 1'b0;
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int c, w0, base, rbase;

    step();
    step();
    reset_i = 1'b0;
    chk_on  = 1'b1;

    // Reset state
    peek(12'h004, d, c);
    check("reset_status", d, 32'h0000_0000);
    check("reset_irq", 32'(irq_o), 32'd0);
    check("reset_wr", 32'(uart_wr_o), 32'd0);
    peek(12'h008, d, c);
    check("reset_ctrl", d, 32'h0000_0000);

    // Three queued bytes, 10-cycle busy each
    base = wr_data.size();
    w0   = cyc;
    bus_write(12'h000, 32'h41);
    bus_write(12'h000, 32'h42);
    bus_write(12'h000, 32'h43);
    for (int i = 0; i < 100; i++) begin
      peek(12'h004, d, c);
      if (!d[0]) break;
    end
    check("tx_drained_status", d, 32'h0000_0000);
    check("txbusy_fall_cycle", 32'(c - w0), 32'd40);
    check("tx_pulse_count", 32'(wr_data.size() - base), 32'd3);
    check("tx_byte0", 32'(wr_data[base]), 32'h41);
    check("tx_byte1", 32'(wr_data[base+1]), 32'h42);
    check("tx_byte2", 32'(wr_data[base+2]), 32'h43);
    check("tx_pulse0_lat", 32'(wr_cyc[base] - w0), 32'd2);
    check("tx_pulse1_lat", 32'(wr_cyc[base+1] - w0), 32'd15);
    check("tx_pulse2_lat", 32'(wr_cyc[base+2] - w0), 32'd28);

    // TX overflow with the core stalled
    stall = 1'b1;
    base  = wr_data.size();
    for (int i = 0; i < 6; i++) bus_write(12'h000, 32'h60 + i);
    repeat (4) step();
    peek(12'h004, d, c);
    check("txovf_status", d, 32'h0004_0025);
    bus_write(12'h004, 32'h20);
    peek(12'h004, d, c);
    check("txovf_cleared", d, 32'h0004_0005);
    stall = 1'b0;
    for (int i = 0; i < 300; i++) begin
      peek(12'h004, d, c);
      if (!d[0]) break;
    end
    check("txovf_drained", d, 32'h0000_0000);
    check("txovf_pulse_count", 32'(wr_data.size() - base), 32'd5);
    check("txovf_last_byte", 32'(wr_data[base+4]), 32'h64);

    // RX overrun and drain
    rbase = rd_cnt;
    for (int i = 0; i < 5; i++) inject(8'h10 + 8'(i));
    peek(12'h004, d, c);
    check("rxovr_status", d, 32'h0000_041A);
    check("rx_rd_pulses", 32'(rd_cnt - rbase), 32'd5);
    for (int i = 0; i < 4; i++) begin
      bus_read(12'h000, d);
      check("rx_read_data", d, 32'h10 + i);
    end
    bus_read(12'h000, d);
    check("rx_read_empty", d, 32'h0000_0000);
    peek(12'h004, d, c);
    check("rx_empty_status", d, 32'h0000_0010);
    bus_write(12'h004, 32'h10);
    peek(12'h004, d, c);
    check("rxovr_cleared", d, 32'h0000_0000);

    // Interrupts
    bus_write(12'h008, 32'h1);
    addr_i = 12'h004;
    uart_valid_i = 1'b1; uart_rx_data_i = 8'h55;
    step();
    uart_valid_i = 1'b0;
    @(negedge clk);
    check("irq_rxvalid_set", 32'(rdata_o[1]), 32'd1);
    check("irq_not_yet", 32'(irq_o), 32'd0);
    step();
    @(negedge clk);
    check("irq_rx_rise", 32'(irq_o), 32'd1);
    step();
    bus_read(12'h000, d);
    check("irq_rx_data", d, 32'h55);
    @(negedge clk);
    check("irq_hold", 32'(irq_o), 32'd1);
    step();
    @(negedge clk);
    check("irq_rx_fall", 32'(irq_o), 32'd0);
    step();
    bus_write(12'h008, 32'h2);
    step();
    @(negedge clk);
    check("irq_tx_idle", 32'(irq_o), 32'd1);
    step();
    bus_write(12'h008, 32'h0);

    // Reset while the transmitter waits for busy to drop
    stall = 1'b1;
    base  = wr_data.size();
    for (int i = 0; i < 4; i++) bus_write(12'h000, 32'h70 + i);
    repeat (5) step();
    peek(12'h004, d, c);
    check("pre_reset_status", d, 32'h0003_0001);
    reset_i = 1'b1;
    stall   = 1'b0;
    step();
    reset_i = 1'b0;
    peek(12'h004, d, c);
    check("post_reset_status", d, 32'h0000_0000);
    check("post_reset_txdata", 32'(uart_tx_data_o), 32'd0);
    repeat (20) step();
    check("post_reset_no_wr", 32'(wr_data.size() - base), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
